// File: rtl/ratfl_chkpt_ctrl.sv
// Branch checkpoint controller: program-ordered ring of RAT/free-list snapshots,
// freed on correct resolve and replayed for one cycle on a mispredict.
module ratfl_chkpt_ctrl #(
  parameter int PREG_W    = 6,
  parameter int PREGS     = 64,
  parameter int NUM_CHKPT = 4,
  parameter int TAG_W     = 4,
  parameter int COUNT_W   = $clog2(PREGS) + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   chkpt_we_i,
  input  logic [TAG_W-1:0]       chkpt_tag_i,
  input  logic [32*PREG_W-1:0]   chkpt_rat_map_i,
  input  logic [PREG_W-1:0]      chkpt_fl_head_i,
  input  logic [PREG_W-1:0]      chkpt_fl_tail_i,
  input  logic [COUNT_W-1:0]     chkpt_fl_free_count_i,
  input  logic                   resolve_valid_i,
  input  logic [TAG_W-1:0]       resolve_tag_i,
  input  logic                   resolve_mispredict_i,
  output logic                   chkpt_full_o,
  output logic                   rat_recover_o,
  output logic [32*PREG_W-1:0]   rat_recover_map_o,
  output logic                   fl_recover_o,
  output logic [PREG_W-1:0]      fl_recover_head_o,
  output logic [PREG_W-1:0]      fl_recover_tail_o,
  output logic [COUNT_W-1:0]     fl_recover_free_count_o,
  output logic                   flush_o,
  output logic                   overflow_o,
  output logic                   unknown_tag_o
);

  localparam int IDX_W = $clog2(NUM_CHKPT);
  localparam int CNT_W = IDX_W + 1;
  localparam int MAP_W = 32 * PREG_W;
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {ST_IDLE, ST_RECOVER} state_e;

  state_e               state_q, state_d;
  logic [NUM_CHKPT-1:0] valid_q, valid_d;
  logic [IDX_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [TAG_W-1:0]     tag_q      [NUM_CHKPT];
  logic [MAP_W-1:0]     map_mem    [NUM_CHKPT];
  logic [PREG_W-1:0]    fl_hd_mem  [NUM_CHKPT];
  logic [PREG_W-1:0]    fl_tl_mem  [NUM_CHKPT];
  logic [COUNT_W-1:0]   fl_cnt_mem [NUM_CHKPT];

  logic [MAP_W-1:0]     rec_map_q;
  logic [PREG_W-1:0]    rec_hd_q, rec_tl_q;
  logic [COUNT_W-1:0]   rec_cnt_q;
  logic                 overflow_q, unknown_q;

  logic [NUM_CHKPT-1:0] hit, flush_slot;
  logic [IDX_W-1:0]     slot_off [NUM_CHKPT];
  logic [IDX_W-1:0]     match_idx, m_off;
  logic                 match_any, full, idle;
  logic                 mispredict, do_resolve, do_alloc, do_overflow, do_unknown, do_retire;

  // Offsets are measured from the oldest slot so a full ring (head == tail) is unambiguous.
  for (genvar gi = 0; gi < NUM_CHKPT; gi++) begin : g_slot
    assign hit[gi]        = valid_q[gi] && (tag_q[gi] == resolve_tag_i);
    assign slot_off[gi]   = IDX_W'(gi) - head_q;
    assign flush_slot[gi] = (slot_off[gi] >= m_off) && (CNT_W'(slot_off[gi]) < cnt_q);
  end

  always_comb begin
    match_idx = '0;
    for (int i = 0; i < NUM_CHKPT; i++) begin
      if (hit[i]) match_idx = IDX_W'(i);
    end
  end

  assign match_any   = |hit;
  assign m_off       = match_idx - head_q;
  assign full        = (cnt_q == CNT_W'(NUM_CHKPT));
  assign idle        = (state_q == ST_IDLE);
  assign mispredict  = idle && resolve_valid_i && match_any && resolve_mispredict_i;
  assign do_resolve  = idle && resolve_valid_i && match_any && !resolve_mispredict_i;
  assign do_unknown  = idle && resolve_valid_i && !match_any;
  assign do_alloc    = idle && chkpt_we_i && !mispredict && !full;
  assign do_overflow = idle && chkpt_we_i && !mispredict && full;
  assign do_retire   = idle && !mispredict && (cnt_q != '0) && !valid_q[head_q];

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE:    if (mispredict) state_d = ST_RECOVER;
      ST_RECOVER: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (do_resolve) valid_d[match_idx] = 1'b0;
    if (do_alloc) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + IDX_ONE;
    end
    if (do_retire) head_d = head_q + IDX_ONE;
    unique case ({do_alloc, do_retire})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
    if (mispredict) begin
      valid_d = valid_q & ~flush_slot;
      tail_d  = match_idx;
      cnt_d   = {1'b0, m_off};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      valid_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
      unknown_q  <= 1'b0;
      rec_map_q  <= '0;
      rec_hd_q   <= '0;
      rec_tl_q   <= '0;
      rec_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
      overflow_q <= do_overflow;
      unknown_q  <= do_unknown;
      if (mispredict) begin
        rec_map_q <= map_mem[match_idx];
        rec_hd_q  <= fl_hd_mem[match_idx];
        rec_tl_q  <= fl_tl_mem[match_idx];
        rec_cnt_q <= fl_cnt_mem[match_idx];
      end
    end
  end

  // Payload storage is only meaningful under its valid bit, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (do_alloc) begin
      tag_q[tail_q]      <= chkpt_tag_i;
      map_mem[tail_q]    <= chkpt_rat_map_i;
      fl_hd_mem[tail_q]  <= chkpt_fl_head_i;
      fl_tl_mem[tail_q]  <= chkpt_fl_tail_i;
      fl_cnt_mem[tail_q] <= chkpt_fl_free_count_i;
    end
  end

  assign chkpt_full_o            = full;
  assign rat_recover_o           = (state_q == ST_RECOVER);
  assign fl_recover_o            = (state_q == ST_RECOVER);
  assign flush_o                 = (state_q == ST_RECOVER);
  assign rat_recover_map_o       = rec_map_q;
  assign fl_recover_head_o       = rec_hd_q;
  assign fl_recover_tail_o       = rec_tl_q;
  assign fl_recover_free_count_o = rec_cnt_q;
  assign overflow_o              = overflow_q;
  assign unknown_tag_o           = unknown_q;

endmodule

// File: tb/tb_ratfl_chkpt_ctrl.sv
// Bench for ratfl_chkpt_ctrl: directed vector table, reset-in-recover sequence,
// then random traffic against a queue-based program-order model.
module tb_ratfl_chkpt_ctrl;
  localparam int PREG_W = 6, PREGS = 64, NUM_CHKPT = 4, TAG_W = 4, COUNT_W = 7;
  localparam int MAP_W = 32 * PREG_W;
  localparam int NVEC = 27;

  logic clk, rst_ni;
  logic chkpt_we, resolve_valid, resolve_mis;
  logic [TAG_W-1:0] chkpt_tag, resolve_tag;
  logic [MAP_W-1:0] chkpt_map, rec_map;
  logic [PREG_W-1:0] chkpt_hd, chkpt_tl, rec_hd, rec_tl;
  logic [COUNT_W-1:0] chkpt_cnt, rec_cnt;
  logic full, rat_rec, fl_rec, flush, ovf, unk;

  ratfl_chkpt_ctrl #(.PREG_W(PREG_W), .PREGS(PREGS), .NUM_CHKPT(NUM_CHKPT), .TAG_W(TAG_W)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .chkpt_we_i(chkpt_we), .chkpt_tag_i(chkpt_tag), .chkpt_rat_map_i(chkpt_map),
    .chkpt_fl_head_i(chkpt_hd), .chkpt_fl_tail_i(chkpt_tl), .chkpt_fl_free_count_i(chkpt_cnt),
    .resolve_valid_i(resolve_valid), .resolve_tag_i(resolve_tag), .resolve_mispredict_i(resolve_mis),
    .chkpt_full_o(full), .rat_recover_o(rat_rec), .rat_recover_map_o(rec_map),
    .fl_recover_o(fl_rec), .fl_recover_head_o(rec_hd), .fl_recover_tail_o(rec_tl),
    .fl_recover_free_count_o(rec_cnt), .flush_o(flush), .overflow_o(ovf), .unknown_tag_o(unk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [MAP_W-1:0] mk_map(input logic [5:0] m5);
    logic [MAP_W-1:0] m;
    for (int k = 0; k < 32; k++) m[k*PREG_W +: PREG_W] = PREG_W'(k);
    m[5*PREG_W +: PREG_W] = m5;
    return m;
  endfunction

  task automatic drive(input logic we, input logic [3:0] tag, input logic [5:0] m5,
                       input logic [6:0] cin, input logic rv, input logic [3:0] rtag, input logic mis);
    chkpt_we = we; chkpt_tag = tag; chkpt_map = mk_map(m5);
    chkpt_hd = m5; chkpt_tl = m5 + 6'd1; chkpt_cnt = cin;
    resolve_valid = rv; resolve_tag = rtag; resolve_mis = mis;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic we; logic [3:0] tag; logic [5:0] m5; logic [6:0] cin;
    logic rv; logic [3:0] rtag; logic mis;
    logic e_full, e_ovf, e_unk, e_rec; logic [5:0] e_m5; logic [6:0] e_cnt_out;
    logic [2:0] e_cnt; logic [1:0] e_head, e_tail;
  } vec_t;
  vec_t tbl [NVEC];

  function automatic vec_t mk(int we, int tag, int m5, int cin, int rv, int rtag, int mis,
                              int f, int o, int u, int r, int em5, int ecnt, int c, int h, int t);
    vec_t v;
    v.we = 1'(we); v.tag = 4'(tag); v.m5 = 6'(m5); v.cin = 7'(cin);
    v.rv = 1'(rv); v.rtag = 4'(rtag); v.mis = 1'(mis);
    v.e_full = 1'(f); v.e_ovf = 1'(o); v.e_unk = 1'(u); v.e_rec = 1'(r);
    v.e_m5 = 6'(em5); v.e_cnt_out = 7'(ecnt); v.e_cnt = 3'(c); v.e_head = 2'(h); v.e_tail = 2'(t);
    return v;
  endfunction

  // Reference model: live checkpoints in program order, oldest at index 0.
  typedef struct {
    logic [3:0] tag; logic resolved; logic [MAP_W-1:0] map;
    logic [5:0] hd, tl; logic [6:0] cnt;
  } ent_t;
  ent_t mq[$];
  logic m_rec, m_ovf, m_unk;
  logic [MAP_W-1:0] m_map;
  logic [5:0] m_hd, m_tl;
  logic [6:0] m_cnt;

  function automatic bit is_live(input logic [3:0] t);
    foreach (mq[i]) if (!mq[i].resolved && mq[i].tag == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    int k;
    bit ret;
    ent_t e;
    m_ovf = 1'b0;
    m_unk = 1'b0;
    k = -1;
    if (m_rec) begin
      m_rec = 1'b0;
    end else begin
      if (resolve_valid)
        foreach (mq[i]) if (!mq[i].resolved && mq[i].tag == resolve_tag) k = i;
      if (resolve_valid && k >= 0 && resolve_mis) begin
        m_map = mq[k].map; m_hd = mq[k].hd; m_tl = mq[k].tl; m_cnt = mq[k].cnt;
        while (mq.size() > k) void'(mq.pop_back());
        m_rec = 1'b1;
      end else begin
        ret = (mq.size() > 0) && mq[0].resolved;
        if (resolve_valid && k >= 0) mq[k].resolved = 1'b1;
        if (resolve_valid && k < 0) m_unk = 1'b1;
        if (chkpt_we) begin
          if (mq.size() == NUM_CHKPT) m_ovf = 1'b1;
          else begin
            e.tag = chkpt_tag; e.resolved = 1'b0; e.map = chkpt_map;
            e.hd = chkpt_hd; e.tl = chkpt_tl; e.cnt = chkpt_cnt;
            mq.push_back(e);
          end
        end
        if (ret) void'(mq.pop_front());
      end
    end
  endtask

  initial begin
    logic we_r, rv_r, mis_r;
    logic [3:0] t_r, rt_r;
    logic [3:0] live[$];
    rst_ni = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);

    tbl[0]  = mk(1,1,0,0,    0,0,0,   0,0,0,0, 0,0,   1,0,1);
    tbl[1]  = mk(1,2,0,0,    0,0,0,   0,0,0,0, 0,0,   2,0,2);
    tbl[2]  = mk(1,3,0,0,    0,0,0,   0,0,0,0, 0,0,   3,0,3);
    tbl[3]  = mk(1,4,0,0,    0,0,0,   1,0,0,0, 0,0,   4,0,0);
    tbl[4]  = mk(1,5,0,0,    0,0,0,   1,1,0,0, 0,0,   4,0,0);
    tbl[5]  = mk(0,0,0,0,    0,0,0,   1,0,0,0, 0,0,   4,0,0);
    tbl[6]  = mk(0,0,0,0,    1,1,0,   1,0,0,0, 0,0,   4,0,0);
    tbl[7]  = mk(0,0,0,0,    1,2,0,   0,0,0,0, 0,0,   3,1,0);
    tbl[8]  = mk(0,0,0,0,    1,3,0,   0,0,0,0, 0,0,   2,2,0);
    tbl[9]  = mk(0,0,0,0,    1,4,0,   0,0,0,0, 0,0,   1,3,0);
    tbl[10] = mk(0,0,0,0,    0,0,0,   0,0,0,0, 0,0,   0,0,0);
    tbl[11] = mk(1,1,0,0,    0,0,0,   0,0,0,0, 0,0,   1,0,1);
    tbl[12] = mk(1,2,0,0,    0,0,0,   0,0,0,0, 0,0,   2,0,2);
    tbl[13] = mk(0,0,0,0,    1,2,0,   0,0,0,0, 0,0,   2,0,2);
    tbl[14] = mk(0,0,0,0,    1,1,0,   0,0,0,0, 0,0,   2,0,2);
    tbl[15] = mk(0,0,0,0,    0,0,0,   0,0,0,0, 0,0,   1,1,2);
    tbl[16] = mk(0,0,0,0,    0,0,0,   0,0,0,0, 0,0,   0,2,2);
    tbl[17] = mk(1,3,40,30,  0,0,0,   0,0,0,0, 0,0,   1,2,3);
    tbl[18] = mk(1,7,41,29,  0,0,0,   0,0,0,0, 0,0,   2,2,0);
    tbl[19] = mk(1,9,42,28,  0,0,0,   0,0,0,0, 0,0,   3,2,1);
    tbl[20] = mk(0,0,0,0,    1,7,1,   0,0,0,1, 41,29, 1,2,3);
    tbl[21] = mk(0,0,0,0,    0,0,0,   0,0,0,0, 41,29, 1,2,3);
    tbl[22] = mk(0,0,0,0,    1,9,0,   0,0,1,0, 41,29, 1,2,3);
    tbl[23] = mk(1,10,43,27, 1,3,1,   0,0,0,1, 40,30, 0,2,2);
    tbl[24] = mk(1,11,44,26, 1,12,1,  0,0,0,0, 40,30, 0,2,2);
    tbl[25] = mk(0,0,0,0,    1,12,0,  0,0,1,0, 40,30, 0,2,2);
    tbl[26] = mk(0,0,0,0,    0,0,0,   0,0,0,0, 40,30, 0,2,2);

    repeat (2) @(negedge clk);
    chk("reset_full", full, 0);
    chk("reset_rat_recover", rat_rec, 0);
    chk("reset_fl_recover", fl_rec, 0);
    chk("reset_flush", flush, 0);
    chk("reset_overflow", ovf, 0);
    chk("reset_unknown", unk, 0);
    chk("reset_map", rec_map, 0);
    chk("reset_fl_data", {rec_hd, rec_tl, rec_cnt}, 0);
    rst_ni = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      drive(tbl[i].we, tbl[i].tag, tbl[i].m5, tbl[i].cin, tbl[i].rv, tbl[i].rtag, tbl[i].mis);
      step();
      $display("vec %0d: we=%0b tag=%0d rv=%0b rtag=%0d mis=%0b -> full=%0b ovf=%0b unk=%0b rec=%0b cnt=%0d",
               i, tbl[i].we, tbl[i].tag, tbl[i].rv, tbl[i].rtag, tbl[i].mis, full, ovf, unk, rat_rec, dut.cnt_q);
      chk($sformatf("vec%0d_full", i), full, tbl[i].e_full);
      chk($sformatf("vec%0d_overflow", i), ovf, tbl[i].e_ovf);
      chk($sformatf("vec%0d_unknown", i), unk, tbl[i].e_unk);
      chk($sformatf("vec%0d_strobes", i), {rat_rec, fl_rec, flush}, {3{tbl[i].e_rec}});
      chk($sformatf("vec%0d_map5", i), rec_map[5*PREG_W +: PREG_W], tbl[i].e_m5);
      chk($sformatf("vec%0d_free_count", i), rec_cnt, tbl[i].e_cnt_out);
      chk($sformatf("vec%0d_cnt", i), dut.cnt_q, tbl[i].e_cnt);
      chk($sformatf("vec%0d_head_tail", i), {dut.head_q, dut.tail_q}, {tbl[i].e_head, tbl[i].e_tail});
    end

    // Asynchronous reset landing in the middle of a recovery cycle.
    drive(1, 1, 20, 50, 0, 0, 0); step();
    drive(1, 2, 21, 49, 0, 0, 0); step();
    drive(0, 0, 0, 0, 1, 2, 1);   step();
    $display("seq rst: mispredict tag 2 -> rec=%0b cnt=%0d", rat_rec, dut.cnt_q);
    chk("rstrec_strobe_before", rat_rec, 1);
    chk("rstrec_count_before", rec_cnt, 49);
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_ni = 1'b0;
    #1;
    $display("seq rst: reset asserted -> rec=%0b flush=%0b cnt=%0d", rat_rec, flush, dut.cnt_q);
    chk("rstrec_strobes", {rat_rec, fl_rec, flush}, 0);
    chk("rstrec_cnt", dut.cnt_q, 0);
    chk("rstrec_data", {rec_hd, rec_tl, rec_cnt}, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    drive(1, 6, 22, 48, 0, 0, 0); step();
    $display("seq rst: alloc tag 6 after reset -> cnt=%0d tail=%0d", dut.cnt_q, dut.tail_q);
    chk("post_rst_cnt", dut.cnt_q, 1);
    chk("post_rst_tail", dut.tail_q, 1);
    chk("post_rst_strobe", rat_rec, 0);

    // Random traffic against the program-order model, from a clean reset.
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    mq.delete();
    m_rec = 1'b0; m_map = '0; m_hd = '0; m_tl = '0; m_cnt = '0;
    for (int c = 0; c < 1500; c++) begin
      we_r = 1'($urandom_range(0, 1));
      t_r = 4'($urandom_range(0, 15));
      for (int tries = 0; tries < 64 && is_live(t_r); tries++) t_r = 4'($urandom_range(0, 15));
      if (is_live(t_r)) we_r = 1'b0;
      rv_r = ($urandom_range(0, 99) < 45);
      live.delete();
      foreach (mq[i]) if (!mq[i].resolved) live.push_back(mq[i].tag);
      if (live.size() > 0 && $urandom_range(0, 4) != 0) rt_r = live[$urandom_range(0, live.size()-1)];
      else rt_r = 4'($urandom_range(0, 15));
      mis_r = ($urandom_range(0, 99) < 20);
      drive(we_r, t_r, 6'($urandom), 7'($urandom), rv_r, rt_r, mis_r);
      for (int w = 0; w < MAP_W/32; w++) chkpt_map[w*32 +: 32] = $urandom;
      model_step();
      step();
      $display("rnd %0d: we=%0b tag=%0d rv=%0b rtag=%0d mis=%0b -> live=%0d rec=%0b",
               c, we_r, t_r, rv_r, rt_r, mis_r, mq.size(), rat_rec);
      chk("rnd_full", full, (mq.size() == NUM_CHKPT));
      chk("rnd_cnt", dut.cnt_q, mq.size());
      chk("rnd_pulses", {ovf, unk}, {m_ovf, m_unk});
      chk("rnd_strobes", {rat_rec, fl_rec, flush}, {3{m_rec}});
      chk("rnd_map", rec_map, m_map);
      chk("rnd_fl_data", {rec_hd, rec_tl, rec_cnt}, {m_hd, m_tl, m_cnt});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
